// File: rtl/sramlike_pkg.sv
// Shared encodings for the sram-like arbiter: FSM states, grant owners and transfer sizes.
package sramlike_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sramlike_arb_pick.sv
// Combinational owner picker shared by the IDLE and back-to-back paths.
// SRAMLIKE_ARB_RR_EN selects round-robin tie-break; otherwise data has fixed priority.
module sramlike_arb_pick
    import sramlike_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
    input  logic last,
    output logic any,
    output logic pick
);

    assign any = inst_req | data_req;

`ifdef SRAMLIKE_ARB_RR_EN
    // On a tie the owner that was not granted last time wins.
    assign pick = (inst_req & data_req) ? ~last : (data_req ? GNT_DATA : GNT_INST);
`else
    logic unused_last;
    assign unused_last = last;
    assign pick = data_req ? GNT_DATA : GNT_INST;
`endif

endmodule

// File: rtl/sramlike_arbiter.sv
// Shares one sram-like channel between the instruction and data requesters, one transaction
// in flight at a time. Define SRAMLIKE_ARB_RR_EN for round-robin arbitration.
//
// Handshake: a request is accepted in the cycle where req and addr_ok are both high; its
// response completes in the cycle where data_ok is high. Requesters hold their fields until addr_ok.
module sramlike_arbiter
    import sramlike_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,

    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,

    output logic              busy,
    output logic              grant
);

    state_t state, state_nx;
    logic   grant_nx;
    logic   take;
    logic   last;
    logic   any, pick;
    logic   gnt_req;

    sramlike_arb_pick u_pick (
        .inst_req (inst_req),
        .data_req (data_req),
        .last     (last),
        .any      (any),
        .pick     (pick)
    );

    assign gnt_req = (grant == GNT_DATA) ? data_req : inst_req;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            grant <= GNT_INST;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
        end
    end

`ifdef SRAMLIKE_ARB_RR_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  last <= 1'b0;
        else if (take) last <= pick;
    end
`else
    assign last = 1'b0;
`endif

    // take marks a new arbitration; in DATA it still routes data_ok on the old grant this cycle.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_nx = ST_ADDR;
                    take     = 1'b1;
                end
            end
            ST_ADDR: begin
                if (!gnt_req)       state_nx = ST_IDLE;
                else if (s_addr_ok) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (s_data_ok) begin
                    if (any) begin
                        state_nx = ST_ADDR;
                        take     = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        grant_nx = take ? pick : grant;
    end

    assign busy    = (state != ST_IDLE);
    assign s_req   = (state == ST_ADDR) & gnt_req;
    assign s_wr    = (grant == GNT_DATA) ? data_wr    : inst_wr;
    assign s_size  = (grant == GNT_DATA) ? data_size  : inst_size;
    assign s_addr  = (grant == GNT_DATA) ? data_addr  : inst_addr;
    assign s_wdata = (grant == GNT_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = (state == ST_ADDR) & (grant == GNT_INST) & s_addr_ok;
    assign data_addr_ok = (state == ST_ADDR) & (grant == GNT_DATA) & s_addr_ok;
    assign inst_data_ok = (state == ST_DATA) & (grant == GNT_INST) & s_data_ok;
    assign data_data_ok = (state == ST_DATA) & (grant == GNT_DATA) & s_data_ok;

    assign inst_rdata = s_rdata;
    assign data_rdata = s_rdata;

endmodule

// File: doc/sramlike_arbiter.md
Name: sramlike_arbiter

Overview:
- Shares one sram-like channel, feeding the AXI bridge, between two sram-like requesters: the instruction port and the data port.
- Sits between the cache layer and cpu_axi_interface.
- Allows one transaction in flight at a time. The response is routed back to the requester that was granted.
- By default, data requests win over instruction requests.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read/write data width

Ports:
- aclk  in  1  clock; all state updates on the rising edge
- aresetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction requester asserts a request
- inst_wr  in  1  1 = write
- inst_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr  in  ADDR_W  request address
- inst_wdata  in  DATA_W  write data
- inst_rdata  out  DATA_W  read data returned to the instruction requester
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  response complete
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same as the inst_* set, for the data requester
- s_req  out  1  downstream request
- s_wr  out  1  downstream write flag
- s_size  out  2  downstream size
- s_addr  out  ADDR_W  downstream address
- s_wdata  out  DATA_W  downstream write data
- s_rdata  in  DATA_W  downstream read data
- s_addr_ok  in  1  downstream request accepted
- s_data_ok  in  1  downstream response complete
- busy  out  1  state is not IDLE
- grant  out  1  current owner: 0 = inst, 1 = data

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, grant, and last (used only by the optional feature).
- Reset (aresetn low, any time, including mid-transaction):
  - state = IDLE, grant = 0, last = 0.
  - All outputs are 0: s_req, *_addr_ok, *_data_ok, busy.
  - An in-flight downstream transaction is abandoned; the downstream block is reset by the same signal.
- IDLE:
  - If data_req or inst_req is asserted, pick the owner: data wins ties.
  - Register the owner into grant and move to ADDR on the next edge. Arbitration costs one cycle.
  - Nothing is forwarded while in IDLE.
- ADDR:
  - s_req equals the granted requester's *_req.
  - s_wr, s_size, s_addr and s_wdata come from the granted requester as a mux on grant. Requesters hold these fields stable until addr_ok.
  - The granted *_addr_ok equals s_addr_ok. The other *_addr_ok is 0.
  - On s_req & s_addr_ok, move to DATA.
  - If the granted requester drops its req before addr_ok (protocol violation, tolerated), return to IDLE.
- DATA:
  - s_req = 0.
  - The granted *_data_ok equals s_data_ok. The other *_data_ok is 0.
  - s_rdata is driven to both *_rdata ports at all times.
  - On s_data_ok:
    - If any *_req is asserted in the same cycle, re-arbitrate and go straight to ADDR with the new grant (back-to-back, no IDLE bubble).
    - Otherwise go to IDLE.
- A requester's req asserted while the other requester owns the channel stays pending. It gets no addr_ok until it is granted.
- No combinational path from s_addr_ok or s_data_ok to s_req.
- busy = (state != IDLE). grant is the registered owner value.
- When s_data_ok arrives together with a simultaneous request, the data_ok routing uses the old grant. The new grant takes effect from the next cycle.

Optional Feature:
- Macro: SRAMLIKE_ARB_RR_EN.
- When defined, arbitration is round-robin:
  - On a tie, the requester that was not last granted wins.
  - last is updated on every grant.
  - This applies in both IDLE and the DATA back-to-back path.
- When not defined, data has fixed priority, and last is not implemented.

Decomposition:
- Shared package sramlike_pkg holds:
  - state encodings ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2
  - grant encodings GNT_INST = 1'b0, GNT_DATA = 1'b1
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
- Sub-module sramlike_arb_pick: a combinational picker.
  - Inputs: inst_req, data_req, last.
  - Outputs: any and pick.
  - It is used by both the IDLE path and the DATA back-to-back path.

Test Plan:
- Single inst read: inst_req with addr 0xBFC00000, s_addr_ok one cycle after s_req, s_data_ok with rdata 0x3C1D0000 two cycles later → inst_addr_ok and inst_data_ok each pulse exactly once, inst_rdata = 0x3C1D0000, data_* handshakes stay 0, busy clears one cycle after data_ok.
- Simultaneous requests in IDLE: inst_req and data_req asserted together, data is a write with addr 0x80001000, wdata 0xDEADBEEF, size 2 → data is granted first and s_addr/s_wdata match; inst is granted back-to-back on data's s_data_ok with no IDLE cycle.
- Request during ownership: data_req rises while inst is in DATA → data_addr_ok stays 0 until inst_data_ok; s_req never asserts while in DATA.
- Reset mid-transaction: aresetn driven low while in ADDR with s_req = 1 → s_req, busy and grant read 0 immediately, without waiting for a clock edge; the first request after reset is accepted normally.
- Back-pressure: s_addr_ok held low for 5 cycles → s_req and s_addr stay stable; no addr_ok reaches either requester before s_addr_ok.
- With SRAMLIKE_ARB_RR_EN, both requesters held permanently → grants alternate data, inst, data, inst over 4 transactions; without the macro, all 4 go to data.
